// File: rtl/fifo_param.sv
// Parametrised synchronous single-clock FIFO with registered read data, occupancy
// count, programmable almost-full/almost-empty thresholds and a sticky error flag.
module fifo_param #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  pop,
   input  logic [ADDR_WIDTH:0]   af_thresh,
   input  logic [ADDR_WIDTH:0]   ae_thresh,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  error
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] ONE        = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] ZERO       = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0] DEPTH_VAL  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] DEPTH_M1   = {1'b0, {ADDR_WIDTH{1'b1}}};

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH:0]   wr_ptr_reg;
   logic [ADDR_WIDTH:0]   rd_ptr_reg;
   logic [ADDR_WIDTH:0]   count_reg;
   logic [DATA_WIDTH-1:0] data_out_reg;
   logic                  valid_out_reg;
   logic                  full_reg;
   logic                  empty_reg;
   logic                  almost_full_reg;
   logic                  almost_empty_reg;
   logic                  error_reg;

   logic                  push_ok;
   logic                  pop_ok;
   logic [ADDR_WIDTH:0]   count_next;
   logic                  full_next;
   logic                  empty_next;
   logic                  almost_full_next;
   logic                  almost_empty_next;
   logic                  error_next;

   // A push into a full FIFO is only legal when a pop frees the oldest slot this edge.
   assign push_ok = push & (~full_reg | pop);
   assign pop_ok  = pop & ~empty_reg;

   always_comb begin
      count_next = count_reg;
      if (push_ok && !pop_ok) begin
         count_next = count_reg + ONE;
      end else if (!push_ok && pop_ok) begin
         count_next = count_reg - ONE;
      end
   end

   always_comb begin
      empty_next        = (count_next == ZERO);
      full_next         = (count_next == DEPTH_VAL);
      almost_empty_next = (count_next >= ONE) && (count_next <= ae_thresh);
      almost_full_next  = (count_next >= ONE) && (count_next >= af_thresh) &&
                          (count_next <= DEPTH_M1);
      error_next        = error_reg | (push & full_reg & ~pop) | (pop & empty_reg);
   end

   // Storage is deliberately left out of reset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg       <= ZERO;
         rd_ptr_reg       <= ZERO;
         count_reg        <= ZERO;
         data_out_reg     <= {DATA_WIDTH{1'b0}};
         valid_out_reg    <= 1'b0;
         full_reg         <= 1'b0;
         empty_reg        <= 1'b1;
         almost_full_reg  <= 1'b0;
         almost_empty_reg <= 1'b0;
         error_reg        <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + ONE;
         end
         // Reading the old slot before the same-edge write gives read-before-write when full.
         if (pop_ok) begin
            rd_ptr_reg   <= rd_ptr_reg + ONE;
            data_out_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
         end
         valid_out_reg    <= pop_ok;
         count_reg        <= count_next;
         full_reg         <= full_next;
         empty_reg        <= empty_next;
         almost_full_reg  <= almost_full_next;
         almost_empty_reg <= almost_empty_next;
         error_reg        <= error_next;
      end
   end

   assign data_out     = data_out_reg;
   assign valid_out    = valid_out_reg;
   assign count        = count_reg;
   assign full         = full_reg;
   assign empty        = empty_reg;
   assign almost_full  = almost_full_reg;
   assign almost_empty = almost_empty_reg;
   assign error        = error_reg;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fifo_param;

   localparam int DW    = 4;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [AW:0]   af_thresh = 4'd6;
   logic [AW:0]   ae_thresh = 4'd1;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic [AW:0]   count;
   logic          full, empty, almost_full, almost_empty, error;

   fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .data_out(data_out), .valid_out(valid_out), .count(count),
      .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .error(error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int txn      = 0;

   // Reference model: a plain queue plus the few bits of visible state.
   int q[$];
   int m_dout  = 0;
   int m_valid = 0;
   int m_err   = 0;

   typedef struct {
      bit          push;
      bit          pop;
      logic [3:0]  din;
      int          cnt;
      bit          full;
      bit          empty;
      bit          af;
      bit          ae;
      bit          err;
      bit          valid;
      int          dout;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      m_dout  = 0;
      m_valid = 0;
      m_err   = 0;
   endfunction

   function automatic void model_edge(bit ps, bit pp, int d);
      bit is_full  = (q.size() == DEPTH);
      bit is_empty = (q.size() == 0);
      bit ps_ok    = ps && (!is_full || pp);
      bit pp_ok    = pp && !is_empty;
      if ((ps && is_full && !pp) || (pp && is_empty)) m_err = 1;
      m_valid = 0;
      if (pp_ok) begin
         m_dout  = q.pop_front();
         m_valid = 1;
      end
      if (ps_ok) q.push_back(d);
   endfunction

   task automatic compare_model(input string tag);
      int sz = q.size();
      chk({tag, "_count"}, 32'(count), 32'(sz));
      chk({tag, "_full"}, 32'(full), 32'(sz == DEPTH));
      chk({tag, "_empty"}, 32'(empty), 32'(sz == 0));
      chk({tag, "_af"}, 32'(almost_full),
          32'(sz >= 1 && sz >= int'(af_thresh) && sz <= DEPTH - 1));
      chk({tag, "_ae"}, 32'(almost_empty), 32'(sz >= 1 && sz <= int'(ae_thresh)));
      chk({tag, "_error"}, 32'(error), 32'(m_err));
      chk({tag, "_valid"}, 32'(valid_out), 32'(m_valid));
      chk({tag, "_dout"}, 32'(data_out), 32'(m_dout));
   endtask

   task automatic show();
      $display("txn %0d push=%0b pop=%0b din=%h -> count=%0d dout=%h valid=%0b full=%0b empty=%0b af=%0b ae=%0b err=%0b",
               txn, push, pop, data_in, count, data_out, valid_out, full, empty,
               almost_full, almost_empty, error);
      txn++;
   endtask

   // One clock of traffic, checked against the model.
   task automatic step(input bit ps, input bit pp, input logic [3:0] d, input string tag);
      push    = ps;
      pop     = pp;
      data_in = d;
      model_edge(ps, pp, int'(d));
      @(posedge clk);
      #1;
      show();
      compare_model(tag);
      push = 1'b0;
      pop  = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_count"}, 32'(count), 0);
      chk({tag, "_empty"}, 32'(empty), 1);
      chk({tag, "_full"}, 32'(full), 0);
      chk({tag, "_af"}, 32'(almost_full), 0);
      chk({tag, "_ae"}, 32'(almost_empty), 0);
      chk({tag, "_error"}, 32'(error), 0);
      chk({tag, "_valid"}, 32'(valid_out), 0);
      chk({tag, "_dout"}, 32'(data_out), 0);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear before the next edge.
   task automatic do_reset(input string tag);
      #2;
      reset = 1'b0;
      #1;
      check_reset(tag);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   function automatic void add_vec(bit ps, bit pp, int d, int c, bit f, bit e,
                                   bit af, bit ae, bit er, bit v, int dout);
      vec_t r;
      r.push = ps; r.pop = pp; r.din = 4'(d); r.cnt = c; r.full = f; r.empty = e;
      r.af = af; r.ae = ae; r.err = er; r.valid = v; r.dout = dout;
      vecs.push_back(r);
   endfunction

   initial begin
      int lst;
      // Directed table with af_thresh=6, ae_thresh=1.
      for (int i = 1; i <= 8; i++)
         add_vec(1, 0, i, i, i == 8, 0, (i == 6 || i == 7), i == 1, 0, 0, 0);
      add_vec(1, 0, 9, 8, 1, 0, 0, 0, 1, 0, 0);
      for (int k = 1; k <= 8; k++)
         add_vec(0, 1, 0, 8 - k, 0, k == 8, (k == 1 || k == 2), k == 7, 1, 1, k);
      add_vec(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 8);
      add_vec(1, 1, 5, 1, 0, 0, 0, 1, 1, 0, 8);

      repeat (2) @(posedge clk);
      #1;
      check_reset("por");
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         string tag;
         tag = $sformatf("tbl%0d", i);
         push    = vecs[i].push;
         pop     = vecs[i].pop;
         data_in = vecs[i].din;
         @(posedge clk);
         #1;
         show();
         chk({tag, "_count"}, 32'(count), 32'(vecs[i].cnt));
         chk({tag, "_full"}, 32'(full), 32'(vecs[i].full));
         chk({tag, "_empty"}, 32'(empty), 32'(vecs[i].empty));
         chk({tag, "_af"}, 32'(almost_full), 32'(vecs[i].af));
         chk({tag, "_ae"}, 32'(almost_empty), 32'(vecs[i].ae));
         chk({tag, "_error"}, 32'(error), 32'(vecs[i].err));
         chk({tag, "_valid"}, 32'(valid_out), 32'(vecs[i].valid));
         chk({tag, "_dout"}, 32'(data_out), 32'(vecs[i].dout));
      end
      push = 1'b0;
      pop  = 1'b0;

      // Push and pop together while full: oldest word out, new word in, count stays.
      do_reset("rst1");
      for (int i = 1; i <= 8; i++) step(1, 0, 4'(i), "fill");
      step(1, 1, 4'd9, "fullpp");
      chk("fullpp_dout1", 32'(data_out), 1);
      chk("fullpp_valid1", 32'(valid_out), 1);
      chk("fullpp_count8", 32'(count), 8);
      chk("fullpp_full1", 32'(full), 1);
      chk("fullpp_err0", 32'(error), 0);
      for (int k = 2; k <= 9; k++) begin
         step(0, 1, 4'd0, "drain");
         chk("drain_seq", 32'(data_out), 32'(k));
      end

      // Interleaved push/pop across pointer wrap with constant occupancy.
      do_reset("rst2");
      for (int i = 0; i < 3; i++) step(1, 0, 4'($urandom_range(15)), "pre");
      for (int i = 0; i < 20; i++) begin
         step(1, 1, 4'($urandom_range(15)), "wrap");
         chk("wrap_count3", 32'(count), 3);
      end
      chk("wrap_noerr", 32'(error), 0);

      // Reset asserted mid-stream at count=5.
      do_reset("rst3");
      for (int i = 0; i < 5; i++) step(1, 0, 4'(i + 3), "mid");
      chk("mid_count5", 32'(count), 5);
      do_reset("midrst");
      step(1, 0, 4'hA, "post");
      step(0, 1, 4'h0, "post");
      chk("post_dout", 32'(data_out), 32'hA);
      step(0, 1, 4'h0, "post_under");

      // Randomized traffic with live threshold changes.
      do_reset("rst4");
      for (int i = 0; i < 400; i++) begin
         af_thresh = 4'($urandom_range(8, 1));
         ae_thresh = 4'($urandom_range(8, 0));
         lst = int'($urandom_range(99));
         step(lst < 55, ($urandom_range(99)) < 45, 4'($urandom_range(15)), "rnd");
         if (i == 200) do_reset("rnd_rst");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised successor to the team's 16-entry, 4-bit FIFO.
- Synchronous single-clock FIFO with configurable data width and power-of-two depth.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, registered read data with a valid strobe, overflow/underflow protection and a sticky error flag.
- Sits between TLP producer and consumer stages as the generic buffering element.

Parameters:
- DATA_WIDTH, 4: width of each stored word.
- ADDR_WIDTH, 3: pointer width; DEPTH = 2**ADDR_WIDTH entries.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- push  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- pop  input  1  read request.
- af_thresh  input  ADDR_WIDTH+1  almost-full threshold, sampled live every cycle.
- ae_thresh  input  ADDR_WIDTH+1  almost-empty threshold, sampled live every cycle.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  data_out holds a newly popped word this cycle.
- count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  output  1  status flags.
- error  output  1  sticky overflow/underflow indicator.

Behaviour:
- Storage: internal DEPTH x DATA_WIDTH register array, written at wr_ptr and read at rd_ptr. Pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
- Full: pointer low bits equal and wrap bits differ.
- Empty: pointers fully equal.
- Reset (reset=0, asynchronous): pointers=0, count=0, data_out=0, valid_out=0, empty=1, full=0, almost_full=0, almost_empty=0, error=0. Array contents are not reset. Asserting reset mid-operation discards all contents immediately.
- Accept rules, evaluated on the registered state:
  - push_ok = push & (~full | pop).
  - pop_ok = pop & ~empty.
- Push while full without pop: write dropped, pointer held, error<=1.
- Pop while empty: dropped, valid_out stays 0, error<=1. Any simultaneous push is still accepted.
- Push and pop while full: both succeed. The read returns the oldest word (read-before-write), the new word takes its slot, and count stays DEPTH.
- Push and pop while neither full nor empty: both succeed, count unchanged.
- No fall-through: a word pushed into an empty FIFO is poppable from the next cycle.
- Pop latency: on pop_ok at edge N, data_out=mem[rd_ptr] and valid_out=1 after edge N. Otherwise valid_out=0 and data_out holds its last value.
- Pointers increment mod 2**(ADDR_WIDTH+1), so the wrap bit toggles on each wrap of the low bits.
- count_next = count + push_ok - pop_ok. All flags are registered from count_next, so they are valid the same cycle the pointers update (no lag).
- Flag equations:
  - empty = (count_next == 0).
  - full = (count_next == DEPTH).
  - almost_empty = (1 <= count_next <= ae_thresh).
  - almost_full = (af_thresh <= count_next <= DEPTH-1).
  - almost_* never coexist with empty/full. Both almost flags may assert together if the thresholds overlap.
- error: sticky once set; cleared only by reset.

Test Plan (DATA_WIDTH=4, ADDR_WIDTH=3, af_thresh=6, ae_thresh=1):
- Reset, then 8 pushes of 1..8:
  - count steps 1..8.
  - almost_empty=1 only at count 1.
  - almost_full=1 at counts 6-7.
  - full=1 after the 8th push; error=0.
- From full, push 9 without pop: count stays 8, error=1 next cycle. Then 8 pops return 1..8 in order, each valid_out=1 one cycle after its pop; empty=1 after the last.
- From empty, pop only: valid_out=0, data_out unchanged, error=1. Pop+push of 5 together: push accepted, count=1, pop dropped.
- From full (1..8), push 9 with pop: data_out=1, valid_out=1, count=8, full stays 1, error=0. A subsequent drain yields 2..9.
- 20 interleaved push/pop pairs across pointer wrap: output order equals input order, count constant, no error.
- Assert reset mid-stream at count=5 (asynchronous, between edges): all outputs take their reset values immediately. The next push/pop after reset behaves as on an empty FIFO.
